// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PC_F, talks to a variable-latency instruction
// memory, and feeds the IF/ID register with stall, redirect and bubble handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_F,
  input  logic        Stall_D,
  input  logic        PCSrc_D,
  input  logic [31:0] PC_Branch_D,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_Plus4_D,
  output logic        Valid_D,
  output logic        Fetch_Busy
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
  } ifid_t;

  state_t      state, state_nxt;
  logic [31:0] pc_f, pc_nxt;
  logic [31:0] ibuf, ibuf_nxt;
  logic [31:0] tbuf, tbuf_nxt;
  ifid_t       ifid_q, ifid_nxt;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic        pass;
  logic [31:0] pass_word;

  assign pc_plus4 = pc_f + 32'd4;
  assign redirect = PCSrc_D & ~Stall_D;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc_f   <= RESET_PC;
      ibuf   <= '0;
      tbuf   <= '0;
      ifid_q <= '{instr: NOP_INSTR, pc4: 32'd0, vld: 1'b0};
    end else begin
      state  <= state_nxt;
      pc_f   <= pc_nxt;
      ibuf   <= ibuf_nxt;
      tbuf   <= tbuf_nxt;
      ifid_q <= ifid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_f;
    ibuf_nxt  = ibuf;
    tbuf_nxt  = tbuf;
    pass      = 1'b0;
    pass_word = Imem_Rdata;

    case (state)
      FETCH: begin
        if (Imem_Ready) begin
          if (redirect) begin
            pc_nxt = PC_Branch_D;
          end else if (!Stall_F && !Stall_D) begin
            pass   = 1'b1;
            pc_nxt = pc_plus4;
          end else begin
            // A decode stall also parks the word here so it is not lost.
            ibuf_nxt  = Imem_Rdata;
            state_nxt = HOLD;
          end
        end else if (redirect) begin
          tbuf_nxt  = PC_Branch_D;
          state_nxt = DROP;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = PC_Branch_D;
          state_nxt = FETCH;
        end else if (!Stall_F && !Stall_D) begin
          pass      = 1'b1;
          pass_word = ibuf;
          pc_nxt    = pc_plus4;
          state_nxt = FETCH;
        end
      end
      DROP: begin
        if (redirect) tbuf_nxt = PC_Branch_D;
        // The newest redirect wins even when it coincides with the stale response.
        if (Imem_Ready) begin
          pc_nxt    = redirect ? PC_Branch_D : tbuf;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase

    ifid_nxt = ifid_q;
    if (!Stall_D) begin
      if (pass) begin
        ifid_nxt.instr = pass_word;
        ifid_nxt.pc4   = pc_plus4;
        ifid_nxt.vld   = 1'b1;
      end else begin
        ifid_nxt.instr = NOP_INSTR;
        ifid_nxt.vld   = 1'b0;
      end
    end
  end

  assign Imem_Req   = (state != HOLD);
  assign Imem_Addr  = pc_f;
  assign Fetch_Busy = Imem_Req & ~Imem_Ready;
  assign Instr_D    = ifid_q.instr;
  assign PC_Plus4_D = ifid_q.pc4;
  assign Valid_D    = ifid_q.vld;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a short random mix, checked every
// cycle against a queue-based fetch model and pinned by hand-computed values.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, Stall_F, Stall_D, PCSrc_D, Imem_Ready;
  logic [31:0] PC_Branch_D, Imem_Rdata;
  logic        Imem_Req, Valid_D, Fetch_Busy;
  logic [31:0] Imem_Addr, Instr_D, PC_Plus4_D;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .Stall_F(Stall_F), .Stall_D(Stall_D),
    .PCSrc_D(PCSrc_D), .PC_Branch_D(PC_Branch_D),
    .Imem_Ready(Imem_Ready), .Imem_Rdata(Imem_Rdata),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Instr_D(Instr_D),
    .PC_Plus4_D(PC_Plus4_D), .Valid_D(Valid_D), .Fetch_Busy(Fetch_Busy)
  );

  int errors = 0;
  int checks = 0;
  int waited = 0;
  int lat    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Model: PC, at most one parked word, a pending "discard next response" target.
  logic [31:0] m_pc, m_tgt, m_instr, m_pc4, m_w;
  logic        m_vld, m_drop, m_redir, m_have;
  logic        armed = 1'b0;
  logic [31:0] held[$];

  always @(posedge clk) begin
    if (rst) begin
      m_pc = RST_PC; m_tgt = '0; m_drop = 1'b0; held.delete();
      m_instr = NOP; m_pc4 = '0; m_vld = 1'b0; armed = 1'b1;
    end else if (armed) begin
      m_redir = PCSrc_D && !Stall_D;
      if (m_drop) begin
        if (m_redir) m_tgt = PC_Branch_D;
        if (Imem_Ready) begin m_pc = m_tgt; m_drop = 1'b0; end
        if (!Stall_D) begin m_instr = NOP; m_vld = 1'b0; end
      end else begin
        m_have = (held.size() > 0) || Imem_Ready;
        m_w    = (held.size() > 0) ? held[0] : Imem_Rdata;
        if (m_redir) begin
          if (m_have) m_pc = PC_Branch_D;
          else begin m_drop = 1'b1; m_tgt = PC_Branch_D; end
          held.delete();
          m_instr = NOP; m_vld = 1'b0;
        end else if (m_have && !Stall_F && !Stall_D) begin
          m_instr = m_w; m_pc4 = m_pc + 32'd4; m_vld = 1'b1;
          m_pc = m_pc + 32'd4;
          held.delete();
        end else begin
          if (m_have && held.size() == 0) held.push_back(m_w);
          if (!Stall_D) begin m_instr = NOP; m_vld = 1'b0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("req",   {31'd0, Imem_Req},   {31'd0, held.size() == 0});
      chk("addr",  Imem_Addr,           m_pc);
      chk("instr", Instr_D,             m_instr);
      chk("pc4",   PC_Plus4_D,          m_pc4);
      chk("valid", {31'd0, Valid_D},    {31'd0, m_vld});
      chk("busy",  {31'd0, Fetch_Busy}, {31'd0, (held.size() == 0) && !Imem_Ready});
    end
  end

  // Drives one cycle of inputs plus the memory response, then waits past the edge.
  task automatic step(input logic r, input logic sf, input logic sd,
                      input logic ps, input logic [31:0] br);
    logic r_q, rdy_q, req_q;
    rst = r; Stall_F = sf; Stall_D = sd; PCSrc_D = ps; PC_Branch_D = br;
    Imem_Ready = !r && (Imem_Req === 1'b1) && (waited >= lat);
    Imem_Rdata = Imem_Ready ? word(Imem_Addr) : 32'hBAD0_BAD0;
    r_q = r; rdy_q = Imem_Ready; req_q = (Imem_Req === 1'b1);
    @(posedge clk);
    #1;
    if (r_q || rdy_q) waited = 0;
    else if (req_q) waited++;
  endtask

  initial begin
    rst = 1'b1; Stall_F = 0; Stall_D = 0; PCSrc_D = 0; PC_Branch_D = '0;
    Imem_Ready = 0; Imem_Rdata = '0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_instr", Instr_D, 32'h0);
    chk("rst_pc4", PC_Plus4_D, 32'h0);
    chk("rst_valid", {31'd0, Valid_D}, 32'd0);
    chk("rst_req", {31'd0, Imem_Req}, 32'd1);
    chk("rst_addr", Imem_Addr, 32'h0);

    // Zero-wait streaming.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      chk("seq_instr", Instr_D, 32'hDEAD_0000 | (i * 4));
      chk("seq_pc4", PC_Plus4_D, (i + 1) * 4);
      chk("seq_valid", {31'd0, Valid_D}, 32'd1);
    end

    // Both stalls while the word at 8 returns.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0);
      chk("hold_req", {31'd0, Imem_Req}, 32'd0);
      chk("hold_instr", Instr_D, 32'hDEAD_0004);
      chk("hold_pc4", PC_Plus4_D, 32'd8);
    end
    step(0, 0, 0, 0, 0);
    chk("rel_instr", Instr_D, 32'hDEAD_0008);
    chk("rel_pc4", PC_Plus4_D, 32'd12);
    chk("rel_addr", Imem_Addr, 32'd12);

    // Redirect with a ready response.
    step(0, 0, 0, 1, 32'h100);
    chk("br_instr", Instr_D, 32'h0);
    chk("br_valid", {31'd0, Valid_D}, 32'd0);
    chk("br_addr", Imem_Addr, 32'h100);

    // Redirect while the request at 0x10 waits two cycles.
    step(0, 0, 0, 1, 32'h10);
    lat = 2;
    step(0, 0, 0, 1, 32'h200);
    chk("drop_req", {31'd0, Imem_Req}, 32'd1);
    chk("drop_addr_held", Imem_Addr, 32'h10);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("drop_addr", Imem_Addr, 32'h200);
    chk("drop_instr", Instr_D, 32'h0);

    // Second redirect during DROP overwrites the target.
    step(0, 0, 0, 1, 32'h300);
    step(0, 0, 0, 1, 32'h340);
    step(0, 0, 0, 0, 0);
    chk("drop2_addr", Imem_Addr, 32'h340);
    lat = 0;

    // Reset from HOLD.
    step(0, 1, 0, 0, 0);
    chk("hold2_req", {31'd0, Imem_Req}, 32'd0);
    step(1, 1, 0, 0, 0);
    chk("rsth_addr", Imem_Addr, RST_PC);
    chk("rsth_req", {31'd0, Imem_Req}, 32'd1);
    chk("rsth_valid", {31'd0, Valid_D}, 32'd0);
    chk("rsth_pc4", PC_Plus4_D, 32'd0);

    // PC wrap.
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_pre", Imem_Addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr", Imem_Addr, 32'h0);
    chk("wrap_pc4", PC_Plus4_D, 32'h0);
    chk("wrap_instr", Instr_D, 32'h2152_FFFC);

    // Decode-only stall parks the word; branch under Stall_D is ignored.
    step(0, 0, 1, 1, 32'h500);
    chk("sd_req", {31'd0, Imem_Req}, 32'd0);
    chk("sd_instr", Instr_D, 32'h2152_FFFC);
    step(0, 0, 0, 0, 0);
    chk("sd_rel_instr", Instr_D, 32'hDEAD_0000);
    chk("sd_rel_addr", Imem_Addr, 32'd4);

    // Random mix of stalls, branches and latency, checked by the model.
    for (int i = 0; i < 200; i++) begin
      lat = $urandom_range(0, 2);
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1023) << 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
